// File: rtl/pc_redirect_pkg.sv
// Shared pipeline package: fetch FSM encoding, default reset PC, branch_type
// codes used by the comparator, and small helpers for the fetch-redirect logic.
package pc_redirect_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FLUSH  = 2'b01,
        ST_HALTED = 2'b10
    } pc_state_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_type_e;

    // Fetch addresses are word aligned; the low two target bits are dropped.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        return (en && value != 16'hFFFF) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/pc_redirect_stats.sv
// Saturating 16-bit counters of accepted branches and taken redirects.
// Only instantiated when PC_REDIRECT_STATS_EN is defined.
module pc_redirect_stats
    import pc_redirect_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_evt,
    input  logic        taken_evt,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt
);

    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] taken_cnt_q,  taken_cnt_d;

    always_comb begin
        branch_cnt_d = sat_inc16(branch_cnt_q, branch_evt);
        taken_cnt_d  = sat_inc16(taken_cnt_q,  taken_evt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= 16'h0000;
            taken_cnt_q  <= 16'h0000;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: sequential fetch, 1-cycle taken-branch redirect with
// IF/ID squash, HLT stop. Optional statistics counters via PC_REDIRECT_STATS_EN.
module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        ifid_flush,
    output logic        halted,
    output logic        misalign
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt
`endif
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_flush_q, ifid_flush_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;
    logic        branch_evt;
    logic        redirect;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        // Branches and halts are only seen in RUN when ID is not frozen.
        branch_evt = (state_q == ST_RUN) && !stall && !halt && branch_valid;
        redirect   = branch_evt && branch_taken;

        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (redirect) begin
                        pc_d    = align_target(branch_target);
                        state_d = ST_FLUSH;
                        if (branch_target[1:0] != 2'b00) misalign_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            // The redirect slot always completes, even under stall.
            ST_FLUSH: begin
                pc_d    = pc_q + PC_STEP;
                state_d = ST_RUN;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        ifid_flush_d = (state_d == ST_FLUSH);
        halted_d     = (state_d == ST_HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_flush_q <= 1'b0;
            halted_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_flush_q <= ifid_flush_d;
            halted_q     <= halted_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc         = pc_q;
    assign ifid_flush = ifid_flush_q;
    assign halted     = halted_q;
    assign misalign   = misalign_q;

`ifdef PC_REDIRECT_STATS_EN
    pc_redirect_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .branch_evt (branch_evt),
        .taken_evt  (redirect),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus randomized
// traffic against a behavioural model. Stats checks compile with PC_REDIRECT_STATS_EN.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic        ifid_flush;
    logic        halted;
    logic        misalign;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .ifid_flush    (ifid_flush),
        .halted        (halted),
        .misalign      (misalign)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .branch_cnt    (branch_cnt),
        .taken_cnt     (taken_cnt)
`endif
    );

    // Behavioural reference: what the fetch unit should be doing, in plain terms.
    logic [31:0] m_pc;
    bit          m_redirect_slot;
    bit          m_stopped;
    bit          m_misalign;
    int          m_branches;
    int          m_takens;

    task automatic model_step();
        if (rst) begin
            m_pc = 32'h0; m_redirect_slot = 0; m_stopped = 0; m_misalign = 0;
            m_branches = 0; m_takens = 0;
        end else if (m_stopped) begin
            // frozen forever
        end else if (m_redirect_slot) begin
            m_pc = m_pc + 32'd4;
            m_redirect_slot = 0;
        end else if (stall) begin
            // frozen this cycle
        end else if (halt) begin
            m_stopped = 1;
        end else begin
            if (branch_valid) m_branches = (m_branches < 65535) ? m_branches + 1 : 65535;
            if (branch_valid && branch_taken) begin
                m_takens = (m_takens < 65535) ? m_takens + 1 : 65535;
                m_pc = (branch_target / 4) * 4;
                m_redirect_slot = 1;
                if (branch_target % 4 != 0) m_misalign = 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive(input bit s, input bit bv, input bit bt, input logic [31:0] tgt, input bit h);
        stall = s; branch_valid = bv; branch_taken = bt; branch_target = tgt; halt = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 32'h1234_5677, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
        checks++;
        if (pc !== 32'h0 || ifid_flush !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset: pc=%h flush=%b halted=%b misalign=%b, expected pc=0 and flags 0",
                     pc, ifid_flush, halted, misalign);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i * 4);
            checks++;
            if (pc !== exp || ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL seq_%0d: pc=%h flush=%b, expected pc=%h flush=0", i, pc, ifid_flush, exp);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) tick();
        checks++;
        if (pc !== 32'h10) begin
            failures++;
            $display("FAIL redirect_setup: pc=%h, expected 00000010", pc);
        end
        drive(0, 1, 1, 32'h40, 0);
        tick();
        checks++;
        if (pc !== 32'h40 || ifid_flush !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target: pc=%h flush=%b, expected pc=00000040 flush=1", pc, ifid_flush);
        end
        // Stall, branch and halt during the flush slot must all be ignored.
        drive(1, 1, 1, 32'h80, 1);
        tick();
        checks++;
        if (pc !== 32'h44 || ifid_flush !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL redirect_after: pc=%h flush=%b halted=%b, expected pc=00000044 flush=0 halted=0",
                     pc, ifid_flush, halted);
        end
        drive(0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 1, 1, 32'h80, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'h0 || ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d: pc=%h flush=%b, expected pc=0 flush=0", i, pc, ifid_flush);
            end
        end
        drive(0, 0, 0, 32'h0, 0);
        tick();
        checks++;
        if (pc !== 32'h4 || ifid_flush !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: pc=%h flush=%b, expected pc=00000004 flush=0", pc, ifid_flush);
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (2) tick();
        drive(0, 1, 1, 32'h100, 1);
        tick();
        checks++;
        if (pc !== 32'h8 || halted !== 1'b1 || ifid_flush !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter: pc=%h halted=%b flush=%b, expected pc=00000008 halted=1 flush=0",
                     pc, halted, ifid_flush);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, $urandom, 0);
            tick();
            checks++;
            if (pc !== 32'h8 || halted !== 1'b1 || ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL halt_hold_%0d: pc=%h halted=%b flush=%b, expected pc=00000008 halted=1 flush=0",
                         i, pc, halted, ifid_flush);
            end
        end
        drive(1, 1, 1, 32'h200, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
        checks++;
        if (pc !== 32'h0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset: pc=%h halted=%b, expected pc=0 halted=0", pc, halted);
        end
    endtask

    task automatic test_wrap_misalign();
        do_reset();
        drive(0, 1, 1, 32'hFFFF_FFF8, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0);
        tick();
        checks++;
        if (pc !== 32'hFFFF_FFFC || misalign !== 1'b0) begin
            failures++;
            $display("FAIL wrap_setup: pc=%h misalign=%b, expected pc=fffffffc misalign=0", pc, misalign);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap: pc=%h, expected 00000000", pc);
        end
        drive(0, 1, 1, 32'h43, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0);
        checks++;
        if (pc !== 32'h40 || misalign !== 1'b1) begin
            failures++;
            $display("FAIL misalign_set: pc=%h misalign=%b, expected pc=00000040 misalign=1", pc, misalign);
        end
        repeat (5) tick();
        checks++;
        if (misalign !== 1'b1) begin
            failures++;
            $display("FAIL misalign_sticky: misalign=%b, expected 1", misalign);
        end
        do_reset();
        checks++;
        if (misalign !== 1'b0) begin
            failures++;
            $display("FAIL misalign_clear: misalign=%b, expected 0", misalign);
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        model_step();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 40) == 0);
            model_step();
            tick();
            checks++;
            if (pc !== m_pc || ifid_flush !== m_redirect_slot || halted !== m_stopped
                || misalign !== m_misalign) begin
                failures++;
                $display("FAIL random_%0d: pc=%h flush=%b halted=%b misalign=%b, expected pc=%h flush=%b halted=%b misalign=%b",
                         i, pc, ifid_flush, halted, misalign, m_pc, m_redirect_slot, m_stopped, m_misalign);
            end
`ifdef PC_REDIRECT_STATS_EN
            checks++;
            if (int'(branch_cnt) != m_branches || int'(taken_cnt) != m_takens) begin
                failures++;
                $display("FAIL random_stats_%0d: branch_cnt=%0d taken_cnt=%0d, expected %0d %0d",
                         i, branch_cnt, taken_cnt, m_branches, m_takens);
            end
`endif
        end
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
    endtask

`ifdef PC_REDIRECT_STATS_EN
    task automatic test_stats();
        do_reset();
        drive(0, 1, 1, 32'h40, 0); tick();
        drive(0, 0, 0, 32'h0, 0);  tick();
        drive(0, 1, 0, 32'h80, 0); tick();
        drive(0, 1, 1, 32'h90, 0); tick();
        drive(0, 0, 0, 32'h0, 0);  tick();
        checks++;
        if (branch_cnt !== 16'd3 || taken_cnt !== 16'd2) begin
            failures++;
            $display("FAIL stats_count: branch_cnt=%0d taken_cnt=%0d, expected 3 2", branch_cnt, taken_cnt);
        end
        do_reset();
        drive(0, 1, 0, 32'h0, 0);
        repeat (65535) tick();
        checks++;
        if (branch_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_reach_max: branch_cnt=%h, expected ffff", branch_cnt);
        end
        tick();
        drive(0, 0, 0, 32'h0, 0);
        checks++;
        if (branch_cnt !== 16'hFFFF || taken_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stats_saturate: branch_cnt=%h taken_cnt=%h, expected ffff 0000", branch_cnt, taken_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_halt();
        test_wrap_misalign();
        test_random();
`ifdef PC_REDIRECT_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
